// File: rtl/cmp_arb_pkg.sv
// Shared compare-unit arbiter package: function codes, compare helper.
// Counter width applies only when CMP_ARB_STAT_EN is defined.
package cmp_arb_pkg;

  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_NE  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_GEU = 3'b110;

  localparam int STAT_W = 16;

  function automatic logic compare(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  ctrl
  );
    logic eq, ltu, lt;
    eq  = (a == b);
    ltu = (a < b);
    lt  = (a[31] & ~b[31]) | ((a[31] == b[31]) & ltu);
    case (ctrl)
      CMP_EQ:  compare = eq;
      CMP_NE:  compare = ~eq;
      CMP_LT:  compare = lt;
      CMP_LTU: compare = ltu;
      CMP_GE:  compare = ~lt;
      CMP_GEU: compare = ~ltu;
      default: compare = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_share_arb_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr, modulo NREQ.
// Purely combinational; grant is one-hot or zero.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? 2 : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && valid[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/cmp_share_arb.sv
// One 32-bit compare unit shared by NREQ requesters, round-robin, 1-cycle result.
// Define CMP_ARB_STAT_EN to add saturating grant/conflict/hold counters.
module cmp_share_arb
  import cmp_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? 2 : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_ctrl,
  input  logic             resp_hold,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic             resp_c
`ifdef CMP_ARB_STAT_EN
  ,output logic [NREQ*STAT_W-1:0] stat_grant
  ,output logic [STAT_W-1:0]      stat_conflict
  ,output logic [STAT_W-1:0]      stat_hold
`endif
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            c_q, c_d;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win;
  logic            hs;
  logic [31:0]     a_sel, b_sel;
  logic [2:0]      ctrl_sel;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .idx   (win)
  );

  assign req_ready = (rst_n && !resp_hold) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    ctrl_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel    = req_a[32*i +: 32];
        b_sel    = req_b[32*i +: 32];
        ctrl_sel = req_ctrl[3*i +: 3];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    id_d    = id_q;
    c_d     = c_q;
    if (hs) begin
      valid_d = 1'b1;
      id_d    = win;
      c_d     = compare(a_sel, b_sel, ctrl_sel);
      ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end else if (!resp_hold) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      c_q     <= c_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_c     = c_q;

`ifdef CMP_ARB_STAT_EN
  logic [NREQ-1:0][STAT_W-1:0] grant_q, grant_d;
  logic [STAT_W-1:0] conf_q, conf_d, hold_q, hold_d;
  logic [$clog2(NREQ+1)-1:0] nval;

  always_comb begin
    nval = '0;
    for (int i = 0; i < NREQ; i++)
      nval = nval + {{($clog2(NREQ+1)-1){1'b0}}, req_valid[i]};
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    grant_d = grant_q;
    conf_d  = conf_q;
    hold_d  = hold_q;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i] && grant_q[i] != '1)
        grant_d[i] = grant_q[i] + 1'b1;
    if (hs && nval >= 2 && conf_q != '1)
      conf_d = conf_q + 1'b1;
    if (resp_hold && |req_valid && hold_q != '1)
      hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      conf_q  <= '0;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      conf_q  <= conf_d;
      hold_q  <= hold_d;
    end
  end

  assign stat_grant    = grant_q;
  assign stat_conflict = conf_q;
  assign stat_hold     = hold_q;
`endif

endmodule
